// File: rtl/lieat_general_rrarb_stage_if.sv
// Request/response bundle for the N-way round-robin arbiter stage.
// master = requesters plus downstream sink, slave = arbiter stage.
interface lieat_general_rrarb_stage_if #(
    parameter int N  = 4,
    parameter int DW = 32
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    i_valid;
    logic [N-1:0]    i_ready;
    logic [N*DW-1:0] i_data;
    logic            o_valid;
    logic            o_ready;
    logic [DW-1:0]   o_data;
    logic [IDW-1:0]  o_id;

    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_id
    );

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data, o_id
    );
endinterface

// File: rtl/lieat_general_rrarb_stage.sv
// Round-robin arbiter of N valid/ready requesters into one registered output stage.
// Latency 1 cycle from input handshake to o_valid; 1 entry/cycle throughput.
// Backpressure: o_ready low with a full stage holds the entry and drops every i_ready.
module lieat_general_rrarb_stage #(
    parameter int N    = 4,
    parameter int DW   = 32,
    parameter bit MASK = 1'b0
) (
    input logic                      clk,
    input logic                      rstn,
    lieat_general_rrarb_stage_if.slave bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] ptr_nxt;
    logic           gnt_any;
    logic [DW-1:0]  gnt_dat;
    logic           acc;
    logic           take;

    logic           o_valid_q;
    logic [DW-1:0]  data_q;
    logic [IDW-1:0] id_q;

    assign acc  = ~o_valid_q | bus.o_ready;
    // i_ready is held low while in reset so nothing is accepted into a stage being cleared
    assign take = acc & gnt_any & rstn;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!gnt_any && bus.i_valid[IDW'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        gnt_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_idx == IDW'(k)) gnt_dat = bus.i_data[k*DW +: DW];
        end
    end

    always_comb begin
        bus.i_ready = '0;
        for (int k = 0; k < N; k++) begin
            bus.i_ready[k] = take && (gnt_idx == IDW'(k));
        end
    end

    assign ptr_nxt = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + IDW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_valid_q <= 1'b0;
            ptr       <= '0;
        end else if (take) begin
            o_valid_q <= 1'b1;
            ptr       <= ptr_nxt;
        end else if (bus.o_ready) begin
            o_valid_q <= 1'b0;
        end
    end

    // Payload registers carry no reset; o_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (take) begin
            data_q <= gnt_dat;
            id_q   <= gnt_idx;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = (MASK && !o_valid_q) ? '0 : data_q;
    assign bus.o_id    = (MASK && !o_valid_q) ? '0 : id_q;
endmodule
